// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Opcodes, bus direction constants and FSM state type shared by
//               the memory access controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    localparam logic [3:0] OPC_LDR  = 4'b1101;
    localparam logic [3:0] OPC_STR  = 4'b1110;

    localparam logic       RW_READ  = 1'b1;
    localparam logic       RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OPC_LDR) || (op == OPC_STR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_counter
// Description : Loadable down-counter that saturates at zero, with zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_counter #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (i_dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : Sequenced LDR/STR bus controller with wait states, memory
//               ready handshake and illegal-opcode flagging.
//               Optional access timeout enabled by defining MEM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int WAIT_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [3:0]        Opcode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [DATA_W-1:0] Data,
    input  logic [DATA_W-1:0] Din,
    input  logic              MemReady,
    output logic              Busy,
    output logic              Done,
    output logic              Error,
    output logic              LDRSel,
    output logic              AddressBusSel,
    output logic              RW,
    output logic [DATA_W-1:0] LDRDataToDestReg,
    output logic [ADDR_W-1:0] AddressBus,
    output logic [DATA_W-1:0] Dout
);

    localparam logic [7:0] c_wait_init = 8'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        opcode_q, opcode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] ldr_data_q, ldr_data_d;
    logic              error_q, error_d;
    logic              timed_out_q, timed_out_d;

    logic w_in_access;
    logic w_load;
    logic w_wait_zero;
    logic w_complete;
    logic w_timeout;

    assign w_in_access = (state_q == ACCESS);
    assign w_load      = (state_q == IDLE) && Start && is_legal_op(Opcode);
    assign w_complete  = w_in_access && w_wait_zero && MemReady;

    mem_wait_counter #(
        .WIDTH      (8)
    ) u_wait_cnt (
        .i_clk      (Clk),
        .i_rst_n    (Rst_n),
        .i_load     (w_load),
        .i_load_val (c_wait_init),
        .i_dec      (w_in_access),
        .o_zero     (w_wait_zero)
    );

`ifdef MEM_TIMEOUT_EN
    // Loaded with N-1 so the abort lands on the N-th ACCESS cycle.
    localparam logic [15:0] c_timeout_init = 16'(TIMEOUT_CYCLES - 1);
    logic w_timeout_zero;

    mem_wait_counter #(
        .WIDTH      (16)
    ) u_timeout_cnt (
        .i_clk      (Clk),
        .i_rst_n    (Rst_n),
        .i_load     (w_load),
        .i_load_val (c_timeout_init),
        .i_dec      (w_in_access),
        .o_zero     (w_timeout_zero)
    );

    assign w_timeout = w_in_access && w_timeout_zero;
`else
    // Timeout disabled: never fires; the parameter is kept on the interface.
    assign w_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        addr_d      = addr_q;
        data_d      = data_q;
        ldr_data_d  = ldr_data_q;
        error_d     = 1'b0;
        timed_out_d = timed_out_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (is_legal_op(Opcode)) begin
                        opcode_d    = Opcode;
                        addr_d      = Address;
                        data_d      = Data;
                        timed_out_d = 1'b0;
                        state_d     = ACCESS;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ACCESS: begin
                // Completion is checked first so it wins over a coincident timeout.
                if (w_complete) begin
                    if (opcode_q == OPC_LDR) begin
                        ldr_data_d = Din;
                    end
                    state_d = DONE;
                end else if (w_timeout) begin
                    error_d     = 1'b1;
                    timed_out_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            ldr_data_q  <= '0;
            error_q     <= 1'b0;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            ldr_data_q  <= ldr_data_d;
            error_q     <= error_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign Busy             = (state_q != IDLE);
    assign Done             = (state_q == DONE);
    assign Error            = error_q;
    assign LDRSel           = Done && (opcode_q == OPC_LDR) && !timed_out_q;
    assign AddressBusSel    = w_in_access;
    assign RW               = w_in_access ? ((opcode_q == OPC_LDR) ? RW_READ : RW_WRITE) : RW_READ;
    assign LDRDataToDestReg = ldr_data_q;
    assign AddressBus       = w_in_access ? addr_q : '0;
    assign Dout             = (w_in_access && (opcode_q == OPC_STR)) ? data_q : '0;

endmodule
`default_nettype wire
